regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 164 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback merge: ALU and load results share an in-order queue that feeds the register-file
// write port, plus a per-register pending-write scoreboard. Define WB_BYPASS_EN for zero-latency bypass.
`timescale 1ns/1ps
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_rd,
    input  logic [15:0] mem_data,
    input  logic        issue_valid,
    input  logic [3:0]  issue_rd,
    output logic [15:0] busy,
    output logic [3:0]  nD,
    output logic [15:0] D,
    output logic        RegWE,
    output logic        empty,
    output logic        full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } wb_entry_t;

    wb_entry_t     slot_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1_s;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic [15:0]   busy_q, busy_d;
    wb_entry_t     last_q;

    logic          mem_fire_s, alu_fire_s, pop_s, byp_s, we_s;
    logic [1:0]    n_push_s;
    wb_entry_t     mem_ent_s, alu_ent_s, push0_s, push1_s, byp_ent_s, wr_s;

    assign mem_ent_s   = '{rd: mem_rd, data: mem_data};
    assign alu_ent_s   = '{rd: alu_rd, data: alu_data};
    assign mem_fire_s  = mem_valid & mem_ready;
    assign alu_fire_s  = alu_valid & alu_ready;
    assign pop_s       = (count_q != CW'(0));
    assign wr_ptr_p1_s = wr_ptr_q + PW'(1);

    // Readiness from the pre-edge count; the last free slot goes to the load unit.
    always_comb begin
        if (count_q <= CW'(DEPTH - 2)) begin
            mem_ready = 1'b1;
            alu_ready = 1'b1;
        end else if (count_q == CW'(DEPTH - 1)) begin
            mem_ready = 1'b1;
            alu_ready = ~mem_valid;
        end else begin
            mem_ready = 1'b0;
            alu_ready = 1'b0;
        end
    end

    // Enqueue selection: mem ahead of alu; with bypass the first entry skips an empty queue.
    always_comb begin
        byp_s   = 1'b0;
        push0_s = mem_ent_s;
        push1_s = alu_ent_s;
        if (mem_fire_s && alu_fire_s) begin
            n_push_s = 2'd2;
        end else if (mem_fire_s) begin
            n_push_s = 2'd1;
        end else if (alu_fire_s) begin
            n_push_s = 2'd1;
            push0_s  = alu_ent_s;
        end else begin
            n_push_s = 2'd0;
        end
        byp_ent_s = push0_s;
`ifdef WB_BYPASS_EN
        if (Reset_n && (count_q == CW'(0)) && (n_push_s != 2'd0)) begin
            byp_s    = 1'b1;
            n_push_s = n_push_s - 2'd1;
            push0_s  = alu_ent_s;
        end else begin
            byp_s    = 1'b0;
        end
`endif
    end

    // Write port: queue head, else the bypassed entry, else hold the last write.
    always_comb begin
        if (pop_s) begin
            we_s = 1'b1;
            wr_s = slot_q[rd_ptr_q];
        end else if (byp_s) begin
            we_s = 1'b1;
            wr_s = byp_ent_s;
        end else begin
            we_s = 1'b0;
            wr_s = last_q;
        end
    end

    // Next-state for pointers, occupancy and the scoreboard (an issue beats a same-edge retire).
    always_comb begin
        count_d  = count_q + CW'(n_push_s) - CW'(pop_s);
        rd_ptr_d = rd_ptr_q + PW'(pop_s);
        wr_ptr_d = wr_ptr_q + PW'(n_push_s);
        busy_d   = busy_q;
        if (we_s) begin
            busy_d[wr_s.rd] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // State registers; reset drops every queued entry.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '{rd: 4'h0, data: 16'h0000};
            end
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            busy_q   <= 16'h0000;
            last_q   <= '{rd: 4'h0, data: 16'h0000};
        end else begin
            if (n_push_s != 2'd0) begin
                slot_q[wr_ptr_q] <= push0_s;
            end
            if (n_push_s == 2'd2) begin
                slot_q[wr_ptr_p1_s] <= push1_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == CW'(0));
            full_q   <= (count_d == CW'(DEPTH));
            busy_q   <= busy_d;
            if (we_s) begin
                last_q <= wr_s;
            end
        end
    end

    assign RegWE = we_s;
    assign nD    = wr_s.rd;
    assign D     = wr_s.data;
    assign busy  = busy_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a negedge monitor models occupancy, readiness and busy,
// and pops expected writes in order; scenario tasks add targeted timing checks.
`timescale 1ns/1ps
module tb_regfile_writeback;
    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset_n;
    logic alu_valid, alu_ready, mem_valid, mem_ready, issue_valid;
    logic [3:0] alu_rd, mem_rd, issue_rd, nD;
    logic [15:0] alu_data, mem_data, busy, D;
    logic RegWE, empty, full;

    logic d2_alu_valid, d2_alu_ready, d2_mem_valid, d2_mem_ready;
    logic [3:0] d2_alu_rd, d2_mem_rd, d2_nD;
    logic [15:0] d2_alu_data, d2_mem_data, d2_busy, d2_D;
    logic d2_RegWE, d2_empty, d2_full;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .Reset_n(Reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .nD(nD), .D(D), .RegWE(RegWE), .empty(empty), .full(full));

    regfile_writeback #(.DEPTH(2)) u_d2 (
        .clk(clk), .Reset_n(Reset_n),
        .alu_valid(d2_alu_valid), .alu_ready(d2_alu_ready), .alu_rd(d2_alu_rd), .alu_data(d2_alu_data),
        .mem_valid(d2_mem_valid), .mem_ready(d2_mem_ready), .mem_rd(d2_mem_rd), .mem_data(d2_mem_data),
        .issue_valid(1'b0), .issue_rd(4'h0), .busy(d2_busy),
        .nD(d2_nD), .D(d2_D), .RegWE(d2_RegWE), .empty(d2_empty), .full(d2_full));

    int tests = 0;
    int failed = 0;
    int n_retired = 0;
    int cnt;
    logic [19:0] exp_q[$];
    logic [19:0] last_wr, e_wr;
    logic [15:0] m_busy, nb;
    logic e_mr, e_ar, e_we, m_mem_acc, m_alu_acc;

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!Reset_n) begin
            exp_q.delete();
            last_wr = 20'h00000;
            m_busy = 16'h0000;
            m_mem_acc = 1'b0;
            m_alu_acc = 1'b0;
        end else begin
            cnt  = exp_q.size();
            e_mr = (cnt <= DEPTH - 1);
            e_ar = (cnt <= DEPTH - 2) || ((cnt == DEPTH - 1) && !mem_valid);
            tests++; if (mem_ready !== e_mr) begin failed++; $display("FAIL mem_ready: got %b want %b (count %0d)", mem_ready, e_mr, cnt); end
            tests++; if (alu_ready !== e_ar) begin failed++; $display("FAIL alu_ready: got %b want %b (count %0d)", alu_ready, e_ar, cnt); end
            tests++; if (empty !== (cnt == 0)) begin failed++; $display("FAIL empty: got %b want %b", empty, (cnt == 0)); end
            tests++; if (full !== (cnt == DEPTH)) begin failed++; $display("FAIL full: got %b want %b", full, (cnt == DEPTH)); end
            tests++; if (busy !== m_busy) begin failed++; $display("FAIL busy: got %h want %h", busy, m_busy); end
            m_mem_acc = mem_valid && e_mr;
            m_alu_acc = alu_valid && e_ar;
            if (m_mem_acc) exp_q.push_back({mem_rd, mem_data});
            if (m_alu_acc) exp_q.push_back({alu_rd, alu_data});
            e_we = (cnt != 0) || (BYP && (m_mem_acc || m_alu_acc));
            tests++; if (RegWE !== e_we) begin failed++; $display("FAIL RegWE: got %b want %b", RegWE, e_we); end
            nb = m_busy;
            if (e_we) begin
                e_wr = exp_q.pop_front();
                tests++; if ({nD, D} !== e_wr) begin failed++; $display("FAIL write_order: got rd=%0d d=%h want rd=%0d d=%h", nD, D, e_wr[19:16], e_wr[15:0]); end
                last_wr = e_wr;
                n_retired++;
                nb[e_wr[19:16]] = 1'b0;
            end else begin
                tests++; if ({nD, D} !== last_wr) begin failed++; $display("FAIL hold_last: got rd=%0d d=%h want rd=%0d d=%h", nD, D, last_wr[19:16], last_wr[15:0]); end
            end
            if (issue_valid) begin
                tests++; if (m_busy[issue_rd] !== 1'b0) begin failed++; $display("FAIL illegal_issue: rd=%0d already busy (busy %h)", issue_rd, m_busy); end
                nb[issue_rd] = 1'b1;
            end
            m_busy = nb;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_srcs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    // Move to the cycle in which the just-driven transfer is visible on the write port.
    task automatic settle();
`ifdef WB_BYPASS_EN
        #1;
`else
        cyc();
        idle_srcs();
        #1;
`endif
    endtask

    task automatic advance();
`ifdef WB_BYPASS_EN
        cyc();
        idle_srcs();
        #1;
`else
        cyc();
`endif
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_srcs();
        issue_valid = 1'b0; issue_rd = 4'h0; alu_rd = 4'h0; alu_data = 16'h0000; mem_rd = 4'h0; mem_data = 16'h0000;
        d2_alu_valid = 1'b0; d2_mem_valid = 1'b0; d2_alu_rd = 4'h0; d2_mem_rd = 4'h0; d2_alu_data = 16'h0000; d2_mem_data = 16'h0000;
        #12;
        tests++; if (RegWE !== 1'b0) begin failed++; $display("FAIL rst_RegWE: got %b want 0", RegWE); end
        tests++; if ({nD, D} !== 20'h00000) begin failed++; $display("FAIL rst_nD_D: got %h want 00000", {nD, D}); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL rst_flags: got empty=%b full=%b want 1/0", empty, full); end
        tests++; if (busy !== 16'h0000) begin failed++; $display("FAIL rst_busy: got %h want 0000", busy); end
        tests++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin failed++; $display("FAIL rst_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready); end
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
        settle();
        tests++; if ({RegWE, nD, D} !== {1'b1, 4'd3, 16'h1234}) begin failed++; $display("FAIL single_write: got we=%b rd=%0d d=%h want 1/3/1234", RegWE, nD, D); end
        advance();
        tests++; if (empty !== 1'b1 || RegWE !== 1'b0) begin failed++; $display("FAIL single_drain: got empty=%b we=%b want 1/0", empty, RegWE); end
    endtask

    task automatic test_dual_order();
        mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'hAAAA;
        alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h5555;
        settle();
        tests++; if ({RegWE, nD, D} !== {1'b1, 4'd5, 16'hAAAA}) begin failed++; $display("FAIL dual_first: got we=%b rd=%0d d=%h want 1/5/AAAA", RegWE, nD, D); end
        advance();
        tests++; if ({RegWE, nD, D} !== {1'b1, 4'd6, 16'h5555}) begin failed++; $display("FAIL dual_second: got we=%b rd=%0d d=%h want 1/6/5555", RegWE, nD, D); end
        cyc();
        tests++; if (RegWE !== 1'b0 || {nD, D} !== {4'd6, 16'h5555}) begin failed++; $display("FAIL dual_idle_hold: got we=%b rd=%0d d=%h want 0/6/5555", RegWE, nD, D); end
    endtask

    task automatic test_back_to_back();
        int mi = 0;
        int ai = 0;
        int r0 = n_retired;
        bit saw_drop = 1'b0;
        for (int c = 0; c < 40 && (mi < 5 || ai < 5); c++) begin
            mem_valid = (mi < 5); mem_rd = 4'(mi);     mem_data = 16'hA000 + 16'(mi);
            alu_valid = (ai < 5); alu_rd = 4'(8 + ai); alu_data = 16'h5000 + 16'(ai);
            #1;
            if (alu_ready === 1'b0 && mem_ready === 1'b1) saw_drop = 1'b1;
            @(posedge clk);
            #1;
            if (m_mem_acc) mi++;
            if (m_alu_acc) ai++;
        end
        idle_srcs();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
        cyc();
        tests++; if (mi != 5 || ai != 5) begin failed++; $display("FAIL b2b_accept: got mem=%0d alu=%0d want 5/5", mi, ai); end
        tests++; if (saw_drop !== 1'b1) begin failed++; $display("FAIL b2b_alu_drop: got %b want 1", saw_drop); end
        tests++; if (n_retired - r0 != 10) begin failed++; $display("FAIL b2b_retired: got %0d want 10", n_retired - r0); end
        tests++; if (empty !== 1'b1) begin failed++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_busy();
        issue_valid = 1'b1; issue_rd = 4'd7;
        cyc();
        issue_valid = 1'b0;
        tests++; if (busy[7] !== 1'b1) begin failed++; $display("FAIL busy7_set: got %b want 1", busy[7]); end
        cyc();
        cyc();
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h0777;
        settle();
        tests++; if (busy[7] !== 1'b1 || RegWE !== 1'b1 || nD !== 4'd7) begin failed++; $display("FAIL busy7_retire_cycle: got busy=%b we=%b rd=%0d want 1/1/7", busy[7], RegWE, nD); end
        advance();
        tests++; if (busy[7] !== 1'b0) begin failed++; $display("FAIL busy7_clear: got %b want 0", busy[7]); end
        alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h0999;
        settle();
        issue_valid = 1'b1; issue_rd = 4'd9;
        advance();
        issue_valid = 1'b0;
        tests++; if (busy[9] !== 1'b1) begin failed++; $display("FAIL busy9_set_wins: got %b want 1", busy[9]); end
        cyc();
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_rd = 4'd10; mem_data = 16'h0A0A;
        alu_valid = 1'b1; alu_rd = 4'd11; alu_data = 16'h0B0B;
        cyc();
        mem_rd = 4'd12; mem_data = 16'h0C0C;
        alu_rd = 4'd13; alu_data = 16'h0D0D;
        cyc();
        idle_srcs();
        #2;
        Reset_n = 1'b0;
        #1;
        tests++; if (RegWE !== 1'b0 || {nD, D} !== 20'h00000) begin failed++; $display("FAIL midrst_port: got we=%b rd=%0d d=%h want 0/0/0000", RegWE, nD, D); end
        tests++; if (empty !== 1'b1 || full !== 1'b0 || busy !== 16'h0000) begin failed++; $display("FAIL midrst_state: got empty=%b full=%b busy=%h want 1/0/0000", empty, full, busy); end
        cyc();
        cyc();
        Reset_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd14; alu_data = 16'h0E0E;
        settle();
        tests++; if ({RegWE, nD, D} !== {1'b1, 4'd14, 16'h0E0E}) begin failed++; $display("FAIL first_after_release: got we=%b rd=%0d d=%h want 1/14/0E0E", RegWE, nD, D); end
        advance();
        for (int c = 0; c < 4; c++) begin
            tests++; if (RegWE !== 1'b0) begin failed++; $display("FAIL ghost_write: got we=%b rd=%0d d=%h want no write", RegWE, nD, D); end
            cyc();
        end
    endtask

`ifndef WB_BYPASS_EN
    task automatic test_full_depth2();
        d2_mem_valid = 1'b1; d2_mem_rd = 4'd1; d2_mem_data = 16'h0101;
        d2_alu_valid = 1'b1; d2_alu_rd = 4'd2; d2_alu_data = 16'h0202;
        cyc();
        d2_mem_valid = 1'b0; d2_alu_valid = 1'b0;
        #1;
        tests++; if (d2_full !== 1'b1 || d2_empty !== 1'b0) begin failed++; $display("FAIL d2_full: got full=%b empty=%b want 1/0", d2_full, d2_empty); end
        tests++; if (d2_mem_ready !== 1'b0 || d2_alu_ready !== 1'b0) begin failed++; $display("FAIL d2_ready: got mem=%b alu=%b want 0/0", d2_mem_ready, d2_alu_ready); end
        tests++; if ({d2_RegWE, d2_nD, d2_D} !== {1'b1, 4'd1, 16'h0101}) begin failed++; $display("FAIL d2_head: got we=%b rd=%0d d=%h want 1/1/0101", d2_RegWE, d2_nD, d2_D); end
        cyc();
        tests++; if (d2_full !== 1'b0 || {d2_nD, d2_D} !== {4'd2, 16'h0202}) begin failed++; $display("FAIL d2_second: got full=%b rd=%0d d=%h want 0/2/0202", d2_full, d2_nD, d2_D); end
        cyc();
        tests++; if (d2_empty !== 1'b1 || d2_RegWE !== 1'b0) begin failed++; $display("FAIL d2_drain: got empty=%b we=%b want 1/0", d2_empty, d2_RegWE); end
    endtask
`else
    task automatic test_bypass();
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'h00FF;
        #1;
        tests++; if ({RegWE, nD, D} !== {1'b1, 4'd2, 16'h00FF}) begin failed++; $display("FAIL bypass_same_cycle: got we=%b rd=%0d d=%h want 1/2/00FF", RegWE, nD, D); end
        cyc();
        idle_srcs();
        #1;
        tests++; if (empty !== 1'b1 || RegWE !== 1'b0) begin failed++; $display("FAIL bypass_not_queued: got empty=%b we=%b want 1/0", empty, RegWE); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_dual_order();
        test_back_to_back();
        test_busy();
        test_reset_mid();
`ifndef WB_BYPASS_EN
        test_full_depth2();
`else
        test_bypass();
`endif
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
